// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   Owns the fetch PC, issues word requests to instruction memory, buffers
//   returned words together with their PC and hands them to the decoder.
//   Redirects flush buffered words and turn in-flight requests into stale
//   responses that are silently discarded when they return.
//
// Optional build macro: FETCH_MISALIGN_TRAP_EN
//   Adds out_misaligned and a HALT state entered on a misaligned redirect.
//   Without it the low two bits of redirect_pc are ignored.
//
// Ports:
//   clk, rst_n                       core clock, async active-low reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_resp_valid/data             in-order response channel
//   redirect_valid/pc                taken branch / jump from execute
//   out_valid/ready/instruction/pc   decoder channel
//   out_misaligned                   (FETCH_MISALIGN_TRAP_EN only) trap entry marker
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        out_misaligned
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_HALT
`endif
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_stale;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_tag_rd;
    logic [AW-1:0] r_tag_wr;
    logic [31:0]   r_data [FIFO_DEPTH];
    logic [31:0]   r_pcq  [FIFO_DEPTH];
    logic [31:0]   r_tag  [FIFO_DEPTH];

    logic [SW-1:0] w_inflight;
    logic [SW-1:0] w_stale_redir;
    logic          w_req_fire;
    logic          w_stale_rsp;
    logic          w_live_rsp;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_target;
    logic [31:0]   w_push_data;
    logic [31:0]   w_push_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic          r_mis [FIFO_DEPTH];
    logic [31:0]   r_trap_pc;
    logic          r_trap_pend;
    logic          w_trap_push;
    logic          w_mis_redirect;
    logic          w_push_mis;

    assign w_mis_redirect = (redirect_pc[1:0] != 2'b00);
    assign w_trap_push    = (r_state == ST_HALT) && r_trap_pend &&
                            (r_count == '0) && !redirect_valid;
    assign out_misaligned = r_mis[r_rd];
`endif

    // Credit uses registered counts only; a pop this cycle frees no credit yet.
    assign w_inflight     = SW'(r_count) + SW'(r_live) + SW'(r_stale);
    assign imem_req_valid = (r_state == ST_RUN) && (w_inflight < DEPTH_S);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_stale_rsp = imem_resp_valid && (r_stale != '0);
    assign w_live_rsp  = imem_resp_valid && (r_stale == '0);

    assign out_valid       = (r_count != '0);
    assign out_instruction = r_data[r_rd];
    assign out_pc          = r_pcq[r_rd];
    assign w_pop           = out_valid && out_ready;

    assign w_target = redirect_pc & 32'hFFFF_FFFC;

    // Any response arriving in the redirect cycle (stale or live) is consumed
    // there, so it is removed from the outstanding total that becomes stale.
    assign w_stale_redir = SW'(r_stale) + SW'(r_live) + SW'(w_req_fire)
                         - SW'(imem_resp_valid);

    always_comb begin
        w_push      = w_live_rsp && !redirect_valid;
        w_push_data = imem_resp_data;
        w_push_pc   = r_tag[r_tag_rd];
`ifdef FETCH_MISALIGN_TRAP_EN
        w_push_mis  = 1'b0;
        if (w_trap_push) begin
            w_push      = 1'b1;
            w_push_data = 32'h0000_0013;
            w_push_pc   = r_trap_pc;
            w_push_mis  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_live     <= '0;
            r_stale    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_data[i] <= '0;
                r_pcq[i]  <= '0;
                r_tag[i]  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
                r_mis[i]  <= 1'b0;
`endif
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            r_trap_pc   <= '0;
            r_trap_pend <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Flush: a pop this cycle already delivered its word, so simply empty.
            r_count    <= '0;
            r_rd       <= r_wr;
            r_live     <= '0;
            r_stale    <= CW'(w_stale_redir);
            r_tag_rd   <= r_tag_wr;
            r_fetch_pc <= w_target;
            r_state    <= ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_trap_pend <= 1'b0;
            if (w_mis_redirect) begin
                r_state     <= ST_HALT;
                r_trap_pc   <= redirect_pc;
                r_trap_pend <= 1'b1;
            end
`endif
        end else begin
            if (r_state == ST_BOOT) begin
                r_state <= ST_RUN;
            end
            if (w_req_fire) begin
                r_fetch_pc      <= r_fetch_pc + 32'd4;
                r_tag[r_tag_wr] <= r_fetch_pc;
                r_tag_wr        <= r_tag_wr + 1'b1;
            end
            if (w_live_rsp) begin
                r_tag_rd <= r_tag_rd + 1'b1;
            end
            r_live <= r_live + CW'(w_req_fire) - CW'(w_live_rsp);
            if (w_stale_rsp) begin
                r_stale <= r_stale - 1'b1;
            end
            if (w_push) begin
                r_data[r_wr] <= w_push_data;
                r_pcq[r_wr]  <= w_push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                r_mis[r_wr]  <= w_push_mis;
`endif
                r_wr         <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_trap_push) begin
                r_trap_pend <= 1'b0;
            end
`endif
        end
    end

endmodule
